// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: decodes config and pixel-write commands and feeds a
// single-entry write buffer. Optional `PIXEL_BURST_EN` keeps PIX open with address auto-increment.
module spi_cmd_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        cs_n,
    input  logic        active,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [5:0]  wr_data,
    output logic [31:0] cfg,
    output logic        cfg_strobe,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, CFG, ADDR_H, ADDR_L, PIX, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] cfg_q, cfg_d;
    logic        cfg_strobe_q, cfg_strobe_d;
    logic [10:0] addr_q, addr_d;
    logic [10:0] pend_addr_q, pend_addr_d;
    logic [5:0]  pend_data_q, pend_data_d;
    logic        pend_q, pend_d;
    logic        err_q, err_d;
    logic        drain;

    // The VGA reader owns the memory whenever active is high.
    assign drain = pend_q & ~active;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        cfg_d        = cfg_q;
        cfg_strobe_d = 1'b0;
        addr_d       = addr_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        pend_d       = pend_q & ~drain;
        err_d        = err_q;

        if (cs_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == 8'h01) begin
                        state_d  = CFG;
                        cnt_d    = '0;
                        shadow_d = '0;
                    end else if (rx_data == 8'h02) begin
                        state_d = ADDR_H;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                CFG: begin
                    shadow_d = {shadow_q[23:0], rx_data};
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        cfg_d        = {shadow_q[23:0], rx_data};
                        cfg_strobe_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
                ADDR_H: begin
                    addr_d  = {rx_data[2:0], addr_q[7:0]};
                    state_d = ADDR_L;
                end
                ADDR_L: begin
                    addr_d  = {addr_q[10:8], rx_data};
                    state_d = PIX;
                end
                PIX: begin
                    // A buffer that drains this cycle can take the new entry.
                    if (pend_q && !drain) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d      = 1'b1;
                        pend_addr_d = addr_q;
                        pend_data_d = rx_data[5:0];
                    end
`ifdef PIXEL_BURST_EN
                    addr_d = addr_q + 11'd1;
`else
                    state_d = IDLE;
`endif
                end
                DISCARD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shadow_q     <= '0;
            cfg_q        <= '0;
            cfg_strobe_q <= 1'b0;
            addr_q       <= '0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            pend_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            cfg_q        <= cfg_d;
            cfg_strobe_q <= cfg_strobe_d;
            addr_q       <= addr_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
        end
    end

    assign wr_en      = drain;
    assign wr_addr    = pend_addr_q;
    assign wr_data    = pend_data_q;
    assign cfg        = cfg_q;
    assign cfg_strobe = cfg_strobe_q;
    assign busy       = (state_q != IDLE) | pend_q;
    assign err        = err_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: a transaction-level model predicts
// writes and cfg updates; a monitor pops and compares on wr_en / cfg_strobe.
module tb_spi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cs_n;
    logic        active;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [5:0]  wr_data;
    logic [31:0] cfg;
    logic        cfg_strobe;
    logic        busy;
    logic        err;

    spi_cmd_sequencer dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .cs_n(cs_n), .active(active), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cfg(cfg), .cfg_strobe(cfg_strobe),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] a;
        logic [5:0]  d;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    int          total = 0;
    int          bad   = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_cfg[$];
    logic [31:0] m_cfg;
    logic        m_err;
    logic        m_pend;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every write strobe and cfg strobe must match the next prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                wr_t w;
                check("wr_en_during_active", {31'd0, active}, 32'd0);
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", wr_addr, wr_data);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", {21'd0, wr_addr}, {21'd0, w.a});
                    check("wr_data", {26'd0, wr_data}, {26'd0, w.d});
                end
            end
            if (cfg_strobe) begin
                if (exp_cfg.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_cfg_strobe: got cfg %h expected no strobe", cfg);
                end else begin
                    check("cfg_value", cfg, exp_cfg.pop_front());
                end
            end
        end
    end

    // Transaction-level reference: effects of a complete cs_n-framed byte list
    // with active held at a constant level throughout.
    task automatic model(input bq_t b, input logic act);
        int          n;
        logic [10:0] a;
        n = b.size();
        if (!act) m_pend = 1'b0;
        if (n == 0) return;
        if (b[0] == 8'h01) begin
            if (n >= 5) begin
                m_cfg = {b[1], b[2], b[3], b[4]};
                exp_cfg.push_back(m_cfg);
            end
        end else if (b[0] == 8'h02) begin
            if (n >= 4) begin
                a = {b[1][2:0], b[2]};
                for (int i = 3; i < n; i++) begin
                    if (m_pend && act) begin
                        m_err = 1'b1;
                    end else begin
                        exp_wr.push_back('{a: a, d: b[i][5:0]});
                        m_pend = act;
                    end
                    a = a + 11'd1;
                end
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input bq_t b, input logic act);
        int n;
        n = b.size();
        model(b, act);
        active = act;
        if ($urandom_range(0, 3) == 0) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
        end
        cyc();
        rx_valid = 1'b0;
        cs_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_data  = b[i];
            rx_valid = 1'b1;
            cyc();
            rx_valid = 1'b0;
            if (i < n - 1) repeat ($urandom_range(0, 2)) cyc();
        end
        if (n >= 4 && b[0] == 8'h02 && !act) begin
            @(negedge clk);
            check("wr_latency", {31'd0, wr_en}, 32'd1);
            cyc();
        end
        if (n == 5 && b[0] == 8'h01) begin
            @(negedge clk);
            check("strobe_latency", {31'd0, cfg_strobe}, 32'd1);
            cyc();
        end
        cs_n = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        check("err", {31'd0, err}, {31'd0, m_err});
        check("cfg_hold", cfg, m_cfg);
        check("busy", {31'd0, busy}, {31'd0, m_pend});
        cyc();
    endtask

    task automatic release_active(input int hold);
        repeat (hold) begin
            @(negedge clk);
            check("busy_deferred", {31'd0, busy}, {31'd0, m_pend});
        end
        cyc();
        active = 1'b0;
        m_pend = 1'b0;
        repeat (3) cyc();
        check("busy_after_drain", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_wr_addr"}, {21'd0, wr_addr}, 32'd0);
        check({tag, "_wr_data"}, {26'd0, wr_data}, 32'd0);
        check({tag, "_cfg"}, cfg, 32'd0);
        check({tag, "_cfg_strobe"}, {31'd0, cfg_strobe}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        m_cfg = '0; m_err = 1'b0; m_pend = 1'b0;
        exp_wr.delete();
        exp_cfg.delete();
        cyc();
        rst = 1'b0;
        cs_n = 1'b1;
        active = 1'b0;
        rx_valid = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; cs_n = 1'b1; active = 1'b0;
        m_cfg = '0; m_err = 1'b0; m_pend = 1'b0;
        #1 check_all_zero("init");
        repeat (2) cyc();
        rst = 1'b0;
        repeat (2) cyc();

        run_txn('{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
        run_txn('{8'h01, 8'h11, 8'h22}, 1'b0);
        run_txn('{8'h02, 8'h05, 8'h3A, 8'h2D}, 1'b0);
        run_txn('{8'h02, 8'h05, 8'h3A, 8'h2D}, 1'b1);
        release_active(100);
        run_txn('{8'h7F, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);

        // Reset mid-CFG with a write still pending behind active.
        run_txn('{8'h02, 8'h01, 8'h23, 8'h15}, 1'b1);
        cs_n = 1'b0;
        rx_data = 8'h01; rx_valid = 1'b1; cyc();
        rx_data = 8'hDE; cyc();
        rx_valid = 1'b0;
        do_reset();

        run_txn('{8'h02, 8'h01, 8'h02, 8'h03}, 1'b1);
        run_txn('{8'h02, 8'h04, 8'h05, 8'h06}, 1'b1);
        release_active(5);
`ifdef PIXEL_BURST_EN
        run_txn('{8'h02, 8'h07, 8'hFF, 8'h01, 8'h02}, 1'b0);
`endif

        do_reset();
        for (int t = 0; t < 150; t++) begin
            bq_t  b;
            int   k;
            int   npix;
            logic act;
            k = $urandom_range(0, 9);
            act = ($urandom_range(0, 2) == 0);
            b.delete();
            if (k < 3) begin
                b.push_back(8'h01);
                repeat (4) b.push_back(8'($urandom));
            end else if (k == 3) begin
                b.push_back(8'h01);
                repeat ($urandom_range(0, 3)) b.push_back(8'($urandom));
            end else if (k < 7) begin
`ifdef PIXEL_BURST_EN
                npix = $urandom_range(1, 4);
`else
                npix = 1;
`endif
                b.push_back(8'h02);
                repeat (2 + npix) b.push_back(8'($urandom));
            end else if (k == 7) begin
                b.push_back(8'h02);
                repeat ($urandom_range(1, 2)) b.push_back(8'($urandom));
            end else if (k == 8) begin
                b.push_back(8'($urandom_range(3, 255)));
                repeat ($urandom_range(0, 3)) b.push_back(8'($urandom));
            end
            run_txn(b, act);
        end

        active = 1'b0;
        m_pend = 1'b0;
        repeat (5) cyc();
        check("writes_outstanding", exp_wr.size(), 32'd0);
        check("cfg_outstanding", exp_cfg.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: asynchronous reset, active-high.
- rx_data, in, 8: byte from the SPI peripheral.
- rx_valid, in, 1: one-cycle strobe qualifying rx_data.
- cs_n, in, 1: SPI select, synchronous to clk; high = transaction end.
- active, in, 1: VGA active-video flag; high = pixel memory busy with reads.
- wr_en, out, 1: pixel-memory write strobe.
- wr_addr, out, 11: pixel-block write address.
- wr_data, out, 6: RRGGBB pixel value.
- cfg, out, 32: configuration register.
- cfg_strobe, out, 1: one-cycle pulse on cfg update.
- busy, out, 1: transaction or write pending.
- err, out, 1: sticky error flag.

REQ-002 SHALL have no parameters. Widths are fixed at 11-bit address, 6-bit pixel and 32-bit cfg.

Function
REQ-003 SHALL sample rx_data only in cycles where rx_valid=1 and cs_n=0.
REQ-004 SHALL implement FSM states IDLE, CFG, ADDR_H, ADDR_L, PIX, DISCARD.
REQ-005 SHALL decode the IDLE byte as follows:
- 0x01: go to CFG, byte counter = 0.
- 0x02: go to ADDR_H.
- Any other value: set err and go to DISCARD.
REQ-006 In CFG, SHALL shift 4 bytes MSB-first into a shadow register.
REQ-007 After the 4th CFG byte, SHALL load cfg from the shadow register and pulse cfg_strobe high on the next cycle, then return to IDLE.
REQ-008 SHALL never change cfg except by a completed 4-byte CFG sequence. A partial sequence leaves cfg unchanged.
REQ-009 In ADDR_H, SHALL take rx_data[2:0] as address[10:8] and ignore bits [7:3]; in ADDR_L, SHALL take rx_data as address[7:0].
REQ-010 In PIX, SHALL capture rx_data[5:0] plus the current address into a single-entry pending write buffer, then return to IDLE (see REQ-019 for the burst variant).
REQ-011 Memory arbitration: the VGA reader has absolute priority. The SHALL-rule is that wr_en is asserted only in cycles where active=0.
REQ-012 SHALL assert wr_en for exactly one cycle, in the first cycle with the buffer pending and active=0. The buffer clears in that same cycle.
REQ-013 Latency: with active=0, wr_en SHALL assert in the cycle after the PIX byte is sampled.
REQ-014 Simultaneous events:
- If the buffer drains in the same cycle a new PIX byte is sampled, the new entry SHALL be accepted without error.
- If the buffer is full and cannot drain (active=1) when a new PIX byte arrives, the new byte SHALL be dropped, err set, and the pending entry kept.
REQ-015 cs_n=1 in any state SHALL force the FSM to IDLE next cycle and discard partial command state. The pending write buffer SHALL be kept.
REQ-016 DISCARD SHALL ignore all bytes until cs_n=1.
REQ-017 busy SHALL equal (state != IDLE) OR pending.
REQ-018 err SHALL be sticky. Only rst clears it.

Reset
REQ-020 rst=1 SHALL asynchronously force the following, including mid-transaction, and cancel any pending write:
- state = IDLE
- cfg = 0, shadow register = 0
- wr_en = 0, wr_addr = 0, wr_data = 0
- cfg_strobe = 0, busy = 0, err = 0
- pending = 0

Configuration
REQ-019 With macro PIXEL_BURST_EN defined:
- PIX SHALL remain in PIX after each data byte.
- The address SHALL increment by 1 per byte, wrapping 0x7FF to 0x000.
- The FSM exits only via cs_n=1.
REQ-021 Without PIXEL_BURST_EN, SHALL behave per REQ-010: one pixel per command, and no address increment logic is compiled.

Verification
REQ-022 Config write: cs_n=0, bytes 01 DE AD BE EF -> cfg=0xDEADBEEF, cfg_strobe high for exactly 1 cycle, err=0.
REQ-023 Pixel write with active=0: bytes 02 05 3A 2D -> wr_en high for one cycle, next cycle after the last byte, with wr_addr=0x53A and wr_data=0x2D.
REQ-024 Deferred write: same bytes as REQ-023 with active=1 held for 100 cycles -> no wr_en while active=1; wr_en fires in the first cycle active=0; busy=1 until then.
REQ-025 Overflow and bad command:
- Two pixel commands while active=1 -> the second is dropped, err=1, and the first is written once active=0.
- Command 0x7F -> err=1, following bytes ignored until cs_n=1.
REQ-026 Abort and reset:
- cs_n=1 after 01 DE AD -> cfg unchanged, state IDLE.
- rst pulse mid-CFG -> all outputs 0.
REQ-027 Burst (PIXEL_BURST_EN defined): bytes 02 07 FF 01 02 -> writes (0x7FF, 0x01) then (0x000, 0x02).
